ps2_host_core: RTL
==================

# ps2_host_core

Parametrised PS/2 host-side line engine that sits behind the Avalon slave register layer. It synchronises and deglitches the open-collector PS/2 clock and data lines and receives device-to-host frames into a small show-ahead FIFO with parity, framing and overflow reporting. It also transmits host-to-device command bytes using the standard inhibit/request-to-send sequence and checks the device acknowledge. A watchdog recovers both directions from a stalled bus.

## Interface
- SYNC_STAGES, 2: flops in each line synchroniser; minimum 2.
- FILTER_LEN, 4: a line must hold a new level for this many consecutive cycles before the filtered level changes.
- RX_FIFO_DEPTH, 4: receive FIFO entries; power of 2, minimum 2.
- INHIBIT_CYCLES, 5000: cycles the host holds clock low before a transmit; 100 µs at 50 MHz.
- TIMEOUT_CYCLES, 100000: maximum cycles between falling clock edges inside a frame; 2 ms at 50 MHz.
- clk  in  1  single clock for the whole block.
- reset_n  in  1  synchronous reset, active low.
- ps2_clk_i  in  1  raw PS/2 clock pin level.
- ps2_data_i  in  1  raw PS/2 data pin level.
- ps2_clk_oe  out  1  1 = pull clock pin low; 0 = release.
- ps2_data_oe  out  1  1 = pull data pin low; 0 = release.
- rx_data  out  8  FIFO head byte; valid while rx_valid = 1.
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  pop the FIFO head when rx_valid = 1.
- rx_err_parity  out  1  one-cycle pulse when a frame fails odd parity.
- rx_err_frame  out  1  one-cycle pulse on bad start bit, bad stop bit or RX timeout.
- rx_overflow  out  1  one-cycle pulse when a good byte arrives while the FIFO is full.
- tx_data  in  8  command byte.
- tx_valid  in  1  transmit request.
- tx_ready  out  1  high only in IDLE; the transfer is accepted when tx_valid = 1 and tx_ready = 1.
- tx_done  out  1  one-cycle pulse when a transmit ends, whether it succeeded or failed.
- tx_err  out  1  valid with tx_done: 1 = missing acknowledge or timeout.
- busy  out  1  1 in any state other than IDLE.

## Operation
- Front end:
  - Each line passes through its own SYNC_STAGES synchroniser, then a FILTER_LEN stability counter.
  - A falling edge is a filtered 1→0 transition and lasts one cycle.
  - Both filtered levels reset to 1.
- State machine states: IDLE, RX, TX_INHIBIT, TX_REQ, TX_BITS, TX_ACK, TX_WAIT.
- RX frame:
  - 11 bits, each sampled on a falling edge: start (0), data LSB first, odd parity, stop (1).
  - A falling edge in IDLE with data = 0 enters RX.
  - A falling edge in IDLE with data = 1 pulses rx_err_frame and stays in IDLE.
  - At the stop bit:
    - stop = 0: pulse rx_err_frame and discard the byte.
    - Parity wrong: pulse rx_err_parity and discard the byte.
    - Otherwise push the byte. If the FIFO is full, drop the byte and pulse rx_overflow. Every case returns to IDLE.
- TX sequence:
  - On accept, latch tx_data and compute parity, then enter TX_INHIBIT with clk_oe = 1 for INHIBIT_CYCLES.
  - TX_REQ: assert data_oe = 1 (start bit), release the clock, then wait for a falling edge.
  - TX_BITS: after each falling edge, drive the next bit (data bits, then parity, then stop = released), so data_oe = ~bit. The 10th edge after the start moves to TX_ACK.
  - TX_ACK: on the next falling edge sample data. 0 = ack; 1 sets the error flag.
  - TX_WAIT: wait for filtered clock and data both high, then pulse tx_done with tx_err and return to IDLE.
- Watchdog:
  - Counts in every state except IDLE and TX_INHIBIT, and restarts on each falling edge.
  - On reaching TIMEOUT_CYCLES, release both lines and return to IDLE.
  - In RX it pulses rx_err_frame. In TX it pulses tx_done with tx_err = 1.
- FIFO:
  - Show-ahead. A push and a pop in the same cycle on a full FIFO are both accepted, with no overflow.
  - Pointers wrap modulo RX_FIFO_DEPTH.
- Reset values:
  - ps2_clk_oe and ps2_data_oe = 0.
  - rx_valid, every pulse output, tx_err and busy = 0.
  - tx_ready = 1, rx_data = 0x00, FIFO empty, state IDLE.

## Timing
- Line latency from pin change to the filtered edge: SYNC_STAGES + FILTER_LEN cycles.
- rx_valid rises 1 cycle after the stop-bit edge is detected.
- The rx_ready pop takes effect on the next edge; the next head appears in the same cycle.
- Outputs are registered. ps2_*_oe change 1 cycle after a state or bit change.
- Reset asserted mid-transfer releases both lines on the first clk edge with reset_n = 0. No tx_done is issued.
- tx_valid is ignored while busy = 1. RX is not monitored during TX.

## Structure
- Shared package ps2_pkg holds:
  - The state enum.
  - FRAME_BITS = 11.
  - An odd-parity function (returns ~^data).
- Sub-module ps2_line_filter (synchroniser plus stability counter, parameters SYNC_STAGES and FILTER_LEN), instantiated once per line.
- The FIFO is inline.

## Test plan
- Device sends 0x1C with parity 0 and stop 1 → rx_valid = 1, rx_data = 0x1C, no error pulses.
- Device sends 0x1C with parity 1 → exactly one rx_err_parity pulse; rx_valid stays 0.
- Host sends 0xED (parity 1) and the device model acks → clk_oe held 5000 cycles, data bits 1,0,1,1,0,1,1,1 then parity 1 on the line, tx_done = 1 with tx_err = 0.
- With RX_FIFO_DEPTH = 4, device sends 0x01..0x05 with no pops → one rx_overflow pulse on 0x05; pops return 0x01..0x04 in order.
- Device stops its clock after 5 bits → rx_err_frame pulse TIMEOUT_CYCLES after the last edge; the next full frame 0xAA is received cleanly.
- reset_n driven low during TX_BITS → ps2_clk_oe = ps2_data_oe = 0 and tx_ready = 1 after one edge; no tx_done.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host core: controller states, frame length
// and the odd-parity helper used on both the receive and transmit paths.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX,
        ST_TX_INHIBIT,
        ST_TX_REQ,
        ST_TX_BITS,
        ST_TX_ACK,
        ST_TX_WAIT
    } state_e;

    localparam int FRAME_BITS = 11;

    // Parity bit that makes the data byte plus parity contain an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchroniser plus stability counter for one open-collector PS/2 line.
// The filtered level only follows the pin after it has held a new value for FILTER_LEN cycles.
module ps2_line_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic line_i,
    output logic level_o
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   level_q;
    logic                   synced;

    assign synced  = sync_q[SYNC_STAGES-1];
    assign level_o = level_q;

    // Idle bus is high, so the chain and the filtered level start at 1.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q  <= '1;
            cnt_q   <= '0;
            level_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
            if (synced == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
                level_q <= synced;
                cnt_q   <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_core.sv
// PS/2 host line engine: receives device frames into a show-ahead FIFO and sends
// host commands with the inhibit/request-to-send handshake, guarded by a watchdog.
module ps2_host_core
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int RX_FIFO_DEPTH  = 4,
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_err_parity,
    output logic       rx_err_frame,
    output logic       rx_overflow,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic       busy
);

    localparam int TIMER_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
    localparam int PTR_W     = $clog2(RX_FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;

    logic clk_lvl, data_lvl, clk_prev_q, clk_fall;

    ps2_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk     (clk),
        .reset_n (reset_n),
        .line_i  (ps2_clk_i),
        .level_o (clk_lvl)
    );

    ps2_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk     (clk),
        .reset_n (reset_n),
        .line_i  (ps2_data_i),
        .level_o (data_lvl)
    );

    assign clk_fall = clk_prev_q & ~clk_lvl;

    state_e               state_q, state_d;
    logic [3:0]           bitcnt_q, bitcnt_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [8:0]           rx_shift_q, rx_shift_d;
    logic [9:0]           tx_frame_q, tx_frame_d;
    logic                 ack_err_q, ack_err_d;
    logic                 clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
    logic                 perr_q, perr_d, ferr_q, ferr_d, done_q, done_d, txerr_q, txerr_d;
    logic                 ovf_q, tx_ready_q, busy_q;
    logic                 push_req, wd_active, timeout;

    logic [7:0]           fifo_mem_q [RX_FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic                 fifo_full, push, pop;

    assign fifo_full = (count_q == CNT_W'(RX_FIFO_DEPTH));
    assign pop       = rx_ready && (count_q != '0);
    assign push      = push_req && (!fifo_full || pop);

    // Next-state logic; the watchdog overrides whatever the active state decided.
    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        rx_shift_d = rx_shift_q;
        tx_frame_d = tx_frame_q;
        ack_err_d  = ack_err_q;
        clk_oe_d   = clk_oe_q;
        data_oe_d  = data_oe_q;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;
        done_d     = 1'b0;
        txerr_d    = 1'b0;
        push_req   = 1'b0;

        wd_active = (state_q != ST_IDLE) && (state_q != ST_TX_INHIBIT);
        timer_d   = '0;
        if (state_q == ST_TX_INHIBIT || (wd_active && !clk_fall)) begin
            timer_d = timer_q + 1'b1;
        end
        timeout = wd_active && !clk_fall && (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));

        case (state_q)
            ST_IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (tx_valid) begin
                    tx_frame_d = {1'b1, odd_parity(tx_data), tx_data};
                    clk_oe_d   = 1'b1;
                    state_d    = ST_TX_INHIBIT;
                end else if (clk_fall) begin
                    if (!data_lvl) begin
                        bitcnt_d = 4'd1;
                        state_d  = ST_RX;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            ST_RX: begin
                if (clk_fall) begin
                    if (bitcnt_q == 4'(FRAME_BITS - 1)) begin
                        state_d = ST_IDLE;
                        if (!data_lvl) begin
                            ferr_d = 1'b1;
                        end else if (rx_shift_q[8] != odd_parity(rx_shift_q[7:0])) begin
                            perr_d = 1'b1;
                        end else begin
                            push_req = 1'b1;
                        end
                    end else begin
                        rx_shift_d = {data_lvl, rx_shift_q[8:1]};
                        bitcnt_d   = bitcnt_q + 4'd1;
                    end
                end
            end
            ST_TX_INHIBIT: begin
                if (timer_q == TIMER_W'(INHIBIT_CYCLES - 1)) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                    timer_d   = '0;
                    state_d   = ST_TX_REQ;
                end
            end
            ST_TX_REQ: begin
                if (clk_fall) begin
                    data_oe_d  = ~tx_frame_q[0];
                    tx_frame_d = {1'b1, tx_frame_q[9:1]};
                    bitcnt_d   = 4'd1;
                    state_d    = ST_TX_BITS;
                end
            end
            ST_TX_BITS: begin
                // The edge that puts the released stop bit on the line is the last one before the ack.
                if (clk_fall) begin
                    data_oe_d  = ~tx_frame_q[0];
                    tx_frame_d = {1'b1, tx_frame_q[9:1]};
                    bitcnt_d   = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'(FRAME_BITS - 2)) begin
                        state_d = ST_TX_ACK;
                    end
                end
            end
            ST_TX_ACK: begin
                if (clk_fall) begin
                    ack_err_d = data_lvl;
                    state_d   = ST_TX_WAIT;
                end
            end
            ST_TX_WAIT: begin
                if (clk_lvl && data_lvl) begin
                    done_d  = 1'b1;
                    txerr_d = ack_err_q;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (timeout) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            state_d   = ST_IDLE;
            push_req  = 1'b0;
            if (state_q == ST_RX) begin
                ferr_d = 1'b1;
            end else begin
                done_d  = 1'b1;
                txerr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            bitcnt_q   <= '0;
            timer_q    <= '0;
            rx_shift_q <= '0;
            tx_frame_q <= '0;
            ack_err_q  <= 1'b0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            done_q     <= 1'b0;
            txerr_q    <= 1'b0;
            ovf_q      <= 1'b0;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            clk_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            timer_q    <= timer_d;
            rx_shift_q <= rx_shift_d;
            tx_frame_q <= tx_frame_d;
            ack_err_q  <= ack_err_d;
            clk_oe_q   <= clk_oe_d;
            data_oe_q  <= data_oe_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            done_q     <= done_d;
            txerr_q    <= txerr_d;
            ovf_q      <= push_req && fifo_full && !pop;
            tx_ready_q <= (state_d == ST_IDLE);
            busy_q     <= (state_d != ST_IDLE);
            clk_prev_q <= clk_lvl;
        end
    end

    // Show-ahead FIFO: a pop and a push on a full FIFO in the same cycle both succeed.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < RX_FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_mem_q[wr_ptr_q] <= rx_shift_q[7:0];
                wr_ptr_q             <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign ps2_clk_oe    = clk_oe_q;
    assign ps2_data_oe   = data_oe_q;
    assign rx_data       = fifo_mem_q[rd_ptr_q];
    assign rx_valid      = (count_q != '0);
    assign rx_err_parity = perr_q;
    assign rx_err_frame  = ferr_q;
    assign rx_overflow   = ovf_q;
    assign tx_ready      = tx_ready_q;
    assign tx_done       = done_q;
    assign tx_err        = txerr_q;
    assign busy          = busy_q;

endmodule
